// File: rtl/core_bist_ctrl.sv
// Built-in self-test controller: drives LFSR patterns into a combinational logic
// core, compacts its responses in an 8-bit MISR and compares against a golden signature.
module core_bist_ctrl #(
    parameter logic [11:0] SEED = 12'h001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [11:0] num_pat,
    input  logic [7:0]  golden_sig,
    output logic [11:0] pat_out,
    input  logic [7:0]  resp_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  sig_out,
    output logic [1:0]  state_dbg
);

    // start/abort are level-sampled on every rising edge with no handshake:
    // start is acted on only from IDLE/DONE, abort only while busy (RUN/CMP),
    // and abort outranks both start and CMP completion.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [11:0] lfsr;
    logic [11:0] cnt;
    logic [11:0] num_q;
    logic [7:0]  misr;
    logic [11:0] lfsr_nxt;
    logic [7:0]  misr_nxt;
    logic        last_pat;

    always_comb begin
        lfsr_nxt = {lfsr[10:0], lfsr[11] ^ lfsr[5] ^ lfsr[3] ^ lfsr[0]};
    end

    // Feedback taps of the MISR land on bits 2..4.
    always_comb begin
        misr_nxt    = 8'h00;
        misr_nxt[0] = misr[7] ^ resp_in[0];
        misr_nxt[1] = misr[0] ^ resp_in[1];
        misr_nxt[2] = misr[1] ^ resp_in[2] ^ misr[7];
        misr_nxt[3] = misr[2] ^ resp_in[3] ^ misr[7];
        misr_nxt[4] = misr[3] ^ resp_in[4] ^ misr[7];
        misr_nxt[5] = misr[4] ^ resp_in[5];
        misr_nxt[6] = misr[5] ^ resp_in[6];
        misr_nxt[7] = misr[6] ^ resp_in[7];
    end

    assign last_pat  = (cnt == (num_q - 12'd1));
    assign sig_out   = misr;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lfsr    <= SEED;
            cnt     <= 12'd0;
            num_q   <= 12'd0;
            misr    <= 8'h00;
            pat_out <= 12'h000;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        num_q <= num_pat;
                        lfsr  <= SEED;
                        cnt   <= 12'd0;
                        misr  <= 8'h00;
                        pass  <= 1'b0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        if (num_pat != 12'd0) begin
                            state   <= RUN;
                            pat_out <= SEED;
                        end else begin
                            state   <= CMP;
                            pat_out <= 12'h000;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state   <= IDLE;
                        pat_out <= 12'h000;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                    end else begin
                        lfsr <= lfsr_nxt;
                        misr <= misr_nxt;
                        cnt  <= cnt + 12'd1;
                        if (last_pat) begin
                            state   <= CMP;
                            pat_out <= 12'h000;
                        end else begin
                            pat_out <= lfsr_nxt;
                        end
                    end
                end
                CMP: begin
                    busy <= 1'b0;
                    if (abort) begin
                        state <= IDLE;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= (misr == golden_sig);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_bist_ctrl.sv
// Self-checking bench for core_bist_ctrl: a stand-in logic core closes the loop and
// a sequence-level model predicts patterns and signatures.
module tb_core_bist_ctrl;

    localparam logic [11:0] SEED = 12'h001;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [11:0] num_pat;
    logic [7:0]  golden_sig;
    logic [11:0] pat_out;
    logic [7:0]  resp_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  sig_out;
    logic [1:0]  state_dbg;

    int compares = 0;
    int errors   = 0;

    // Core stand-in: either a constant response or a keyed mixing function of the pattern.
    bit         core_en    = 1'b0;
    logic [7:0] core_key   = 8'h00;
    logic [7:0] resp_const = 8'h00;

    core_bist_ctrl #(.SEED(SEED)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .num_pat    (num_pat),
        .golden_sig (golden_sig),
        .pat_out    (pat_out),
        .resp_in    (resp_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .sig_out    (sig_out),
        .state_dbg  (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] core_fn(input logic [11:0] p);
        logic [7:0] a;
        a = p[11:4] ^ p[7:0] ^ {p[3:0], p[11:8]};
        return (a + 8'h35) ^ {p[0], p[11], p[2], p[9], p[4], p[7], p[6], p[5]};
    endfunction

    assign resp_in = core_en ? (core_fn(pat_out) ^ core_key) : resp_const;

    // Reference model: sequence of patterns and the signature they compact into.
    function automatic logic [11:0] lfsr_step(input logic [11:0] l);
        return {l[10:0], ^(l & 12'h829)};
    endfunction

    function automatic logic [7:0] model_resp(input logic [11:0] p);
        return core_en ? (core_fn(p) ^ core_key) : resp_const;
    endfunction

    function automatic logic [7:0] model_sig(input int n);
        logic [11:0] l;
        logic [7:0]  m;
        l = SEED;
        m = 8'h00;
        for (int i = 0; i < n; i++) begin
            m = ({m[6:0], m[7]} ^ (m[7] ? 8'h1C : 8'h00)) ^ model_resp(l);
            l = lfsr_step(l);
        end
        return m;
    endfunction

    // Driver: full test from start to DONE, checking every pattern and the result.
    task automatic run_test(input int n, input logic [7:0] golden, input bit poke);
        logic [11:0] p;
        logic [7:0]  exp_sig;
        logic        exp_pass;
        exp_sig  = model_sig(n);
        exp_pass = (exp_sig == golden);
        @(negedge clk);
        golden_sig = golden;
        num_pat    = n[11:0];
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        p = SEED;
        for (int i = 0; i < n; i++) begin
            compares++;
            if (pat_out !== p || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL run_pat n=%0d i=%0d: pat=%h busy=%b done=%b, want pat=%h busy=1 done=0",
                         n, i, pat_out, busy, done, p);
            end
            if (poke && n >= 4 && i == n / 2) begin
                start   = 1'b1;
                num_pat = 12'($urandom_range(0, 4095));
            end
            if (poke && n >= 4 && i == n / 2 + 1) start = 1'b0;
            p = lfsr_step(p);
            @(negedge clk);
        end
        start = 1'b0;
        compares++;
        if (busy !== 1'b1 || pat_out !== 12'h000 || done !== 1'b0) begin
            errors++;
            $display("FAIL cmp_cycle n=%0d: busy=%b pat=%h done=%b, want busy=1 pat=000 done=0",
                     n, busy, pat_out, done);
        end
        @(negedge clk);
        compares++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== exp_pass || sig_out !== exp_sig || pat_out !== 12'h000) begin
            errors++;
            $display("FAIL result n=%0d: done=%b busy=%b pass=%b sig=%h pat=%h, want done=1 busy=0 pass=%b sig=%h pat=000",
                     n, done, busy, pass, sig_out, pat_out, exp_pass, exp_sig);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_pat = 12'd0; golden_sig = 8'h00;
        #23;
        compares++;
        if (pat_out !== 12'h000 || sig_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_vals: pat=%h sig=%h busy=%b done=%b pass=%b st=%0d, want all zero",
                     pat_out, sig_out, busy, done, pass, state_dbg);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        num_pat = 12'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compares++;
            if (busy !== 1'b0 || pat_out !== 12'h000 || done !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold i=%0d: busy=%b pat=%h done=%b, want 0/000/0", i, busy, pat_out, done);
            end
        end
    endtask

    task automatic test_basic_seq();
        logic [11:0] want [4];
        want[0] = 12'h001; want[1] = 12'h003; want[2] = 12'h007; want[3] = 12'h00F;
        core_en = 1'b0; resp_const = 8'h00;
        @(negedge clk);
        num_pat = 12'd4; golden_sig = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            compares++;
            if (pat_out !== want[i]) begin
                errors++;
                $display("FAIL basic_pat i=%0d: got %h, want %h", i, pat_out, want[i]);
            end
            @(negedge clk);
        end
        @(negedge clk);
        compares++;
        if (done !== 1'b1 || pass !== 1'b1 || sig_out !== 8'h00) begin
            errors++;
            $display("FAIL basic_result: done=%b pass=%b sig=%h, want 1/1/00", done, pass, sig_out);
        end
    endtask

    task automatic test_single();
        core_en = 1'b0; resp_const = 8'h01;
        run_test(1, 8'h01, 1'b0);
        run_test(1, 8'h02, 1'b0);
        compares++;
        if (sig_out !== 8'h01 || pass !== 1'b0) begin
            errors++;
            $display("FAIL single_mismatch: sig=%h pass=%b, want 01/0", sig_out, pass);
        end
    endtask

    task automatic test_zero_patterns();
        core_en = 1'b0; resp_const = 8'h5A;
        run_test(0, 8'h00, 1'b0);
        run_test(0, 8'h11, 1'b0);
    endtask

    task automatic test_abort();
        logic [11:0] p;
        core_en = 1'b1; core_key = 8'hC3;
        @(negedge clk);
        num_pat = 12'd100; golden_sig = model_sig(100); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        p = SEED;
        for (int i = 0; i < 50; i++) begin
            compares++;
            if (pat_out !== p) begin
                errors++;
                $display("FAIL abort_pre i=%0d: got %h, want %h", i, pat_out, p);
            end
            p = lfsr_step(p);
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        compares++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || pat_out !== 12'h000 || sig_out !== model_sig(50)) begin
            errors++;
            $display("FAIL abort_run: busy=%b done=%b pass=%b pat=%h sig=%h, want 0/0/0/000/%h",
                     busy, done, pass, pat_out, sig_out, model_sig(50));
        end
        abort = 1'b1;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b0;
        compares++;
        if (busy !== 1'b0 || done !== 1'b0 || sig_out !== model_sig(50)) begin
            errors++;
            $display("FAIL abort_idle: busy=%b done=%b sig=%h, want 0/0/%h", busy, done, sig_out, model_sig(50));
        end
        run_test(100, model_sig(100), 1'b0);
    endtask

    task automatic test_abort_cmp();
        core_en = 1'b1; core_key = 8'h0F;
        @(negedge clk);
        num_pat = 12'd3; golden_sig = model_sig(3); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        compares++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || sig_out !== model_sig(3)) begin
            errors++;
            $display("FAIL abort_cmp: busy=%b done=%b pass=%b sig=%h, want 0/0/0/%h",
                     busy, done, pass, sig_out, model_sig(3));
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        core_en = 1'b1; core_key = 8'h77;
        run_test(6, 8'h00, 1'b0);
        num_pat = 12'd5; golden_sig = model_sig(5); start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        compares++;
        if (busy !== 1'b1 || pat_out !== SEED || done !== 1'b0 || pass !== 1'b0) begin
            errors++;
            $display("FAIL start_beats_abort: busy=%b pat=%h done=%b pass=%b, want 1/%h/0/0",
                     busy, pat_out, done, pass, SEED);
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        compares++;
        if (!seen || pass !== 1'b1 || sig_out !== model_sig(5)) begin
            errors++;
            $display("FAIL b2b_result: done_seen=%b pass=%b sig=%h, want 1/1/%h", seen, pass, sig_out, model_sig(5));
        end
    endtask

    task automatic test_async_reset();
        core_en = 1'b1; core_key = 8'hA5;
        @(negedge clk);
        num_pat = 12'd40; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        compares++;
        if (pat_out !== 12'h000 || sig_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: pat=%h sig=%h busy=%b done=%b pass=%b st=%0d, want all zero",
                     pat_out, sig_out, busy, done, pass, state_dbg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        compares++;
        if (busy !== 1'b0 || pat_out !== 12'h000) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b pat=%h, want 0/000", busy, pat_out);
        end
        run_test(30, model_sig(30), 1'b1);
    endtask

    task automatic test_random();
        int          n;
        logic [7:0]  g;
        for (int t = 0; t < 6; t++) begin
            core_en  = 1'b1;
            core_key = 8'($urandom);
            n = $urandom_range(1, 60);
            g = ($urandom_range(0, 1) == 1) ? model_sig(n) : 8'($urandom);
            run_test(n, g, t[0]);
        end
    endtask

    task automatic test_full_length();
        core_en = 1'b1; core_key = 8'h00;
        run_test(4095, model_sig(4095), 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_seq();
        test_single();
        test_zero_patterns();
        test_abort();
        test_abort_cmp();
        test_back_to_back();
        test_async_reset();
        test_random();
        test_full_length();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end

endmodule

// File: doc/core_bist_ctrl.md
CORE_BIST_CTRL -- requirements
Module: core_bist_ctrl

Interface
REQ-001 Parameter SEED, default 12'h001, SHALL be the LFSR load value at test start; value 12'h000 is illegal.
REQ-002 Port clk input 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n input 1: reset, asynchronous and active-low.
REQ-004 Port start input 1: level-sampled request; SHALL be honoured only in IDLE or DONE.
REQ-005 Port abort input 1: cancels a test in progress.
REQ-006 Port num_pat input 12: number of patterns to apply, latched on accepted start.
REQ-007 Port golden_sig input 8: expected signature, sampled in CMP.
REQ-008 Port pat_out output 12: registered stimulus to the logic core; bit0..bit11 drive n2,n4,n22,n34,n35,n51,n57,n67,n72,n75,n78,n80.
REQ-009 Port resp_in input 8: combinational core response; bit0..bit7 = n6,n9,n42,n48,n56,n65,n68,n77.
REQ-010 Port busy output 1: high in RUN and CMP.
REQ-011 Port done output 1: high in DONE.
REQ-012 Port pass output 1: compare result, valid while done=1, else 0.
REQ-013 Port sig_out output 8: current MISR contents.

Function
REQ-014 FSM states SHALL be IDLE, RUN, CMP, DONE.
REQ-015 IDLE/DONE + start=1 -> RUN if latched num_pat!=0, else CMP; on that edge lfsr<=SEED, cnt<=0, misr<=0, pass<=0.
REQ-016 In RUN pat_out SHALL equal the lfsr register; first RUN cycle presents SEED.
REQ-017 Each RUN cycle lfsr SHALL shift: fb=l[11]^l[5]^l[3]^l[0]; l<={l[10:0],fb}.
REQ-018 Each RUN cycle misr SHALL absorb resp_in at the same edge (core is combinational, single-cycle latency): m'[0]=m[7]^r[0]; m'[i]=m[i-1]^r[i] for i=1,5,6,7; m'[i]=m[i-1]^r[i]^m[7] for i=2,3,4.
REQ-019 cnt SHALL increment each RUN cycle; on the edge where cnt==num_pat-1 FSM SHALL go to CMP (exactly num_pat patterns applied, num_pat=4095 max).
REQ-020 CMP SHALL last one cycle: pass<=(misr==golden_sig); next state DONE.
REQ-021 DONE SHALL hold pass, sig_out, done until an accepted start or reset.
REQ-022 pat_out SHALL be 12'h000 in IDLE, CMP, DONE.
REQ-023 start while busy=1 SHALL be ignored; num_pat changes during a test SHALL have no effect.
REQ-024 abort=1 in RUN or CMP SHALL return to IDLE next edge with done=0, pass=0, misr retained; abort SHALL have priority over CMP completion and over start; abort in IDLE/DONE SHALL be ignored.
REQ-025 start and abort both high in DONE: start SHALL win (abort ignored outside busy).

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, pat_out=0, sig_out=0, busy=0, done=0, pass=0, cnt=0, lfsr=SEED, regardless of state (including mid-RUN).
REQ-027 After rst_n deasserts, no test SHALL start until start=1 is sampled.

Verification
REQ-028 SEED=001, num_pat=4, resp_in=0: pat_out sequence 001,003,007,00F over 4 cycles, then CMP; golden=00 -> done=1, pass=1, sig_out=00.
REQ-029 num_pat=1, resp_in=8'h01, golden=8'h01 -> sig_out=01, pass=1; same with golden=8'h02 -> pass=0.
REQ-030 num_pat=0, start -> RUN skipped, pat_out stays 000, one CMP cycle, done=1, pass=(golden==00).
REQ-031 num_pat=100, abort asserted at pattern 50 -> IDLE next edge, done=0, pat_out=000; subsequent start runs full 100 patterns from SEED.
REQ-032 rst_n pulsed low mid-RUN, asynchronously between edges -> outputs zero before next clk edge; start re-pulsed during busy has no effect.
REQ-033 Closed loop with the logic core, num_pat=4095: signature SHALL match golden model computed by REQ-017/018 equations; pass=1.
